// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement scheduler.
package ro_meas_pkg;

    localparam int CNT_W = 32;
    localparam int SEL_W = 2;
    localparam logic [CNT_W-1:0] SAT_VAL = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH,
        TX,
        NEXT
    } ro_state_t;

    // Timer width: enough bits to hold the largest phase length minus one.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ro_phase_timer.sv
// Loadable down-counter shared by every timed phase and the TX watchdog.
module ro_phase_timer #(
    parameter int W = 8
) (
    input  logic         data_clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Saturates at zero so it never wraps.
    always_ff @(posedge data_clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator measurement sequencer: clear, gate, settle, latch, transmit.
// Define RO_TX_TIMEOUT_EN to enable the TX watchdog and the tx_err flag.
module ro_meas_sched
    import ro_meas_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 16,
    parameter int NUM_SEL       = 4,
    parameter int TX_TIMEOUT    = 4096
) (
    input  logic             data_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] inv_raw,
    input  logic [CNT_W-1:0] nand_raw,
    input  logic [CNT_W-1:0] nor_raw,
    input  logic             tx_done,
    output logic             ro_cnt_clr,
    output logic             ro_cnt_en,
    output logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] INV_COUNT,
    output logic [CNT_W-1:0] NAND_COUNT,
    output logic [CNT_W-1:0] NOR_COUNT,
    output logic             tx_start,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic             tx_err
);

    localparam int TW = tmr_width(GATE_CYCLES, SETTLE_CYCLES, TX_TIMEOUT);
    localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TX_LD     = TW'(TX_TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SEL - 1);

    ro_state_t        state, state_d;
    logic [SEL_W-1:0] sel_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_zero;
    logic             clr_flags;
    logic             latch;
    logic             tx_first;
    logic             err_set;

    ro_phase_timer #(.W(TW)) u_timer (
        .data_clk (data_clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d   = state;
        sel_d     = sel;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        clr_flags = 1'b0;
        latch     = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    sel_d     = '0;
                    clr_flags = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LD;
                end
            end
            CLEAR: begin
                if (tmr_zero) begin
                    state_d  = GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                end
            end
            GATE: begin
                if (tmr_zero) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            SETTLE: begin
                if (tmr_zero) state_d = LATCH;
            end
            LATCH: begin
                latch    = 1'b1;
                state_d  = TX;
                tmr_load = 1'b1;
                tmr_val  = TX_LD;
            end
            TX: begin
                if (!tx_first && tx_done) begin
                    state_d = NEXT;
`ifdef RO_TX_TIMEOUT_EN
                end else if (tmr_zero) begin
                    state_d = NEXT;
                    err_set = 1'b1;
`endif
                end
            end
            NEXT: begin
                if (sel < SEL_LAST) begin
                    sel_d    = sel + 1'b1;
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else if (continuous) begin
                    sel_d    = '0;
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= '0;
            tx_first   <= 1'b0;
            sat        <= 1'b0;
            INV_COUNT  <= '0;
            NAND_COUNT <= '0;
            NOR_COUNT  <= '0;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            tx_first <= (state == LATCH);
            if (clr_flags) sat <= 1'b0;
            if (latch) begin
                INV_COUNT  <= inv_raw;
                NAND_COUNT <= nand_raw;
                NOR_COUNT  <= nor_raw;
                if (inv_raw == SAT_VAL || nand_raw == SAT_VAL ||
                    nor_raw == SAT_VAL)
                    sat <= 1'b1;
            end
        end
    end

`ifdef RO_TX_TIMEOUT_EN
    logic tx_err_q;

    always_ff @(posedge data_clk) begin
        if (!reset) begin
            tx_err_q <= 1'b0;
        end else if (clr_flags) begin
            tx_err_q <= 1'b0;
        end else if (err_set) begin
            tx_err_q <= 1'b1;
        end
    end

    assign tx_err = tx_err_q;
`else
    logic unused_err;
    assign unused_err = err_set;
    assign tx_err     = 1'b0;
`endif

    assign ro_cnt_clr = (state == CLEAR);
    assign ro_cnt_en  = (state == GATE);
    assign busy       = (state != IDLE);
    assign tx_start   = tx_first;
    assign done       = (state == NEXT) && (sel == SEL_LAST);

endmodule

// File: doc/ro_meas_sched.md
Name: ro_meas_sched

Overview:
- Sequences ring-oscillator frequency measurements for the INV, NAND and NOR ring-oscillator counters.
- Per select value: clears the counters, opens a fixed counting window, waits for settling, latches the three 32-bit counts, then hands them to the serial output stage and waits for it to finish.
- Steps the 2-bit select through all NUM_SEL structures, once per sweep or continuously.
- Sits between the raw ring-oscillator counters and the serial data-output block.

Parameters:
- GATE_CYCLES, 1000000: counting window length in data_clk cycles (>=1).
- SETTLE_CYCLES, 16: length of the clear phase and the post-gate settle phase, in cycles (>=1).
- NUM_SEL, 4: number of select values swept (1..4).
- TX_TIMEOUT, 4096: watchdog limit in cycles (used only with the optional feature).

Ports:
- data_clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- continuous  in  1  1 = restart a sweep automatically after each completed sweep.
- inv_raw  in  32  raw INV ring-oscillator count.
- nand_raw  in  32  raw NAND ring-oscillator count.
- nor_raw  in  32  raw NOR ring-oscillator count.
- tx_done  in  1  serializer finished shifting out the 96 bits.
- ro_cnt_clr  out  1  clear to the raw counters.
- ro_cnt_en  out  1  count enable (gate) to the raw counters.
- sel  out  2  structure select driven to the chip.
- INV_COUNT  out  32  latched INV count.
- NAND_COUNT  out  32  latched NAND count.
- NOR_COUNT  out  32  latched NOR count.
- tx_start  out  1  one-cycle pulse to the serializer.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a sweep.
- sat  out  1  sticky flag: some latched count equalled 32'hFFFFFFFF.
- tx_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0 at a data_clk edge), regardless of state:
  - state=IDLE.
  - sel, all three counts, sat, tx_err = 0.
  - ro_cnt_clr, ro_cnt_en, tx_start, done, busy = 0.
  - Applies equally mid-operation; the gate closes on the following cycle.
- Output decoding: ro_cnt_clr = (state==CLEAR) and ro_cnt_en = (state==GATE), both decoded from the registered state. No combinational path from any input to any output.
- States and transitions:
  - IDLE: on start=1, clear sat and tx_err, set sel=0, go to CLEAR.
  - CLEAR: lasts exactly SETTLE_CYCLES cycles, then GATE.
  - GATE: lasts exactly GATE_CYCLES cycles, then SETTLE.
  - SETTLE: lasts exactly SETTLE_CYCLES cycles with enable low, so the raw counts are stable; then LATCH.
  - LATCH: one cycle. Capture inv_raw, nand_raw, nor_raw into the count outputs. Set sat if any captured value is all-ones. Go to TX.
  - TX: tx_start is high only in the first TX cycle. tx_done is sampled from the second TX cycle onward; when it is 1, go to NEXT.
  - NEXT: one cycle.
    - If sel < NUM_SEL-1: sel=sel+1, go to CLEAR.
    - Otherwise: pulse done. If continuous=1, sel=0 and go to CLEAR; else go to IDLE with sel held.
- Cycles per select: 2*SETTLE_CYCLES + GATE_CYCLES + 2 + (TX wait).
- The phase timer is a single down-counter loaded on each state entry. Width is clog2 of the largest of GATE_CYCLES, SETTLE_CYCLES and TX_TIMEOUT. No wrap-around is permitted.
- Count outputs hold their values until the next LATCH.
- Boundary conditions:
  - start while busy: ignored.
  - tx_done outside TX, or in the first TX cycle: ignored.
  - continuous deasserted mid-sweep: the current sweep completes, then IDLE.
  - start and continuous both high in the NEXT cycle of the last select: behaves as continuous (a single restart).
  - NUM_SEL=1: sel stays 0.

Optional Feature:
- Macro: RO_TX_TIMEOUT_EN.
- Defined: a watchdog counts TX cycles. If tx_done is not seen within TX_TIMEOUT cycles of TX entry, set tx_err (sticky until the next start from IDLE) and go to NEXT as though tx_done had arrived.
- Undefined: TX waits indefinitely and tx_err is tied to 0.

Decomposition:
- Package ro_meas_pkg holds:
  - the state enum (IDLE, CLEAR, GATE, SETTLE, LATCH, TX, NEXT);
  - CNT_W=32, SEL_W=2;
  - the all-ones saturation constant.
- Sub-module ro_phase_timer: a loadable down-counter with load and zero outputs, shared by all timed phases and the watchdog.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-GATE -> ro_cnt_en=0 on the next cycle; counts=0, sel=0, busy=0, flags=0.
- Single sweep: GATE_CYCLES=100, SETTLE_CYCLES=4; a stub counter increments by 1 per enabled cycle; tx_done is returned 5 cycles after each tx_start.
  - Exactly 100 cycles of ro_cnt_en high per select.
  - Latched INV, NAND, NOR = 100.
  - sel goes 0,1,2,3; 4 tx_start pulses; 1 done pulse after the fourth tx_done.
- Saturation: nor_raw forced to 32'hFFFFFFFF during select 2 -> sat rises at LATCH and stays 1 until the next start.
- Continuous: continuous=1 -> done pulses and sel returns to 0 repeatedly. Drop continuous during sel=1 -> the sweep finishes at sel=3, then IDLE, busy=0.
- start while busy: pulse start during GATE -> no restart; sel sequence and cycle timing unchanged.
- Timeout (RO_TX_TIMEOUT_EN, TX_TIMEOUT=50, tx_done never asserted) -> 50 cycles after each tx_start, tx_err=1 and the scheduler advances; done pulses after 4 timeouts.
